comparator_serial: RTL and testbench

COMPARATOR_SERIAL -- requirements
Module: comparator_serial

---
 rtl/comparator_serial.sv | 174 +++++++++++++++++
 tb/tb_comparator_serial.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_serial.sv
// rtl/comparator_serial.sv - multi-cycle chunked magnitude comparator with valid/ready handshake
//
// Compares two N-bit operands W bits per cycle, most significant chunk first,
// and reports exactly one of lt / eq / gt through a valid/ready output.
// Signed compares flip the sign bit of both operands so that a plain unsigned
// chunk compare gives the two's complement ordering.
//
// Optional feature macro: COMPARATOR_SERIAL_EARLY_EXIT_EN
//   defined   : finish on the first differing chunk (data-dependent latency)
//   undefined : always spend K = N/W cycles in BUSY (constant latency)
//
// Ports:
//   clk        in   clock, all state changes on rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   a / b / is_signed are valid
//   in_ready   out  block can accept an operation (IDLE only)
//   a, b       in   N-bit operands
//   is_signed  in   1 = two's complement compare, 0 = unsigned
//   out_valid  out  lt / eq / gt are valid (DONE only)
//   out_ready  in   consumer accepts the result
//   lt, eq, gt out  a < b, a == b, a > b (zero outside DONE)

module comparator_serial #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         is_signed,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         lt,
   output logic         eq,
   output logic         gt
);

   if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("comparator_serial: need 1 <= W <= N and N %% W == 0");
   end

   localparam int K  = (W >= 1) ? (N / W) : 1;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
   localparam logic [N-1:0]  MSB_MASK = N'(1) << (N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [N-1:0]  a_q, b_q;
   logic          signed_q;
   logic [IW-1:0] idx_q;
   logic          dec_q;     // an earlier chunk already differed
   logic          dec_lt_q;  // ...and that chunk said a < b

   logic          accept;
   logic [N-1:0]  a_cmp, b_cmp;
   logic [W-1:0]  a_chunk, b_chunk;
   logic          chunk_diff, chunk_lt;
   logic          decided, cur_lt;
   logic          last_chunk, busy_done;

   assign accept = in_valid && in_ready;

   // Flipping the sign bit maps two's complement order onto unsigned order.
   assign a_cmp = signed_q ? (a_q ^ MSB_MASK) : a_q;
   assign b_cmp = signed_q ? (b_q ^ MSB_MASK) : b_q;

   assign a_chunk = a_cmp[int'(idx_q) * W +: W];
   assign b_chunk = b_cmp[int'(idx_q) * W +: W];

   assign chunk_diff = (a_chunk != b_chunk);
   assign chunk_lt   = (a_chunk < b_chunk);

   // The first differing chunk wins; later chunks cannot override it.
   assign decided    = dec_q || chunk_diff;
   assign cur_lt     = dec_q ? dec_lt_q : chunk_lt;
   assign last_chunk = (idx_q == '0);

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
   assign busy_done = last_chunk || chunk_diff;
`else
   assign busy_done = last_chunk;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = BUSY;
         BUSY:    if (busy_done) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, chunk walk and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         signed_q <= 1'b0;
         idx_q    <= LAST_IDX;
         dec_q    <= 1'b0;
         dec_lt_q <= 1'b0;
         lt       <= 1'b0;
         eq       <= 1'b0;
         gt       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q      <= a;
                  b_q      <= b;
                  signed_q <= is_signed;
                  idx_q    <= LAST_IDX;
                  dec_q    <= 1'b0;
                  dec_lt_q <= 1'b0;
               end
            end
            BUSY: begin
               if (!dec_q && chunk_diff) begin
                  dec_q    <= 1'b1;
                  dec_lt_q <= chunk_lt;
               end
               if (busy_done) begin
                  lt <= decided && cur_lt;
                  gt <= decided && !cur_lt;
                  eq <= !decided;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  lt <= 1'b0;
                  eq <= 1'b0;
                  gt <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_serial.sv
// tb/tb_comparator_serial.sv - scoreboard testbench for comparator_serial

module tb_comparator_serial;

   localparam int N = 32;
   localparam int W = 8;
   localparam int K = N / W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  a = '0;
   logic [N-1:0]  b = '0;
   logic          is_signed = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          lt, eq, gt;

   comparator_serial #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lt        (lt),
      .eq        (eq),
      .gt        (gt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] res;   // {lt, eq, gt}
      int         lat;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   or_mode = 0;    // 0 random, 1 hold low, 2 hold high
   int   first_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [2:0] model(input logic [N-1:0] av, input logic [N-1:0] bv, input bit sv);
      logic l, g;
      if (sv) begin
         l = $signed(av) < $signed(bv);
         g = $signed(av) > $signed(bv);
      end else begin
         l = av < bv;
         g = av > bv;
      end
      return {l, av == bv, g};
   endfunction

   function automatic int exp_lat(input logic [N-1:0] av, input logic [N-1:0] bv);
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
      logic [N-1:0] x;
      x = av ^ bv;
      for (int h = N - 1; h >= 0; h--)
         if (x[h]) return (N - 1 - h) / W + 1;
      return K;
`else
      return K;
`endif
   endfunction

   // Backpressure generator; updates 2 time units after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (or_mode)
            0:       out_ready = ($urandom % 3) != 0;
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: compares every delivered result with the scoreboard head.
   initial begin
      logic ov_prev;
      exp_t e;
      ov_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (out_valid && !ov_prev) first_cyc = cyc;
            ov_prev = out_valid;
            if (out_valid) chk("onehot", 32'($countones({lt, eq, gt})), 32'd1);
            else           chk("idle_zero", {29'd0, lt, eq, gt}, 32'd0);
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_result", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("result", {29'd0, lt, eq, gt}, {29'd0, e.res});
                  chk("latency", first_cyc - e.acc, e.lat);
               end
            end
         end else begin
            ov_prev = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   // Drive one operation; returns 1 time unit after the acceptance edge.
   task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input bit sv);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(negedge clk);
      a = av;
      b = bv;
      is_signed = sv;
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         if (in_ready) begin
            e.res = model(av, bv, sv);
            e.lat = exp_lat(av, bv);
            e.acc = cyc + 1;
            q.push_back(e);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      is_signed = $urandom;
   endtask

   task automatic drain();
      int t;
      or_mode = 2;
      t = 0;
      while ((q.size() != 0 || !in_ready) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [N-1:0] av, bv;
      logic [2:0]   r;
      int           t;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_flags", {29'd0, lt, eq, gt}, 32'd0);

      // Directed corner operands
      send(32'h0000_0001, 32'h0000_0002, 1'b0);
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
      send(32'h8000_0000, 32'h8000_0000, 1'b0);
      send(32'h8000_0000, 32'h8000_0000, 1'b1);

      // Randomized operations with chunk-sharing bias
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom % 3) @(posedge clk);
         av = $urandom;
         case ($urandom % 4)
            0:       bv = $urandom;
            1:       bv = av;
            2:       bv = av ^ (32'd1 << ($urandom % 32));
            default: begin av = $urandom % 16; bv = $urandom % 16; end
         endcase
         send(av, bv, 1'($urandom));
      end

      // Hold result under backpressure while a new request is offered
      drain();
      or_mode = 1;
      av = 32'h0000_0042;
      bv = 32'h0000_0042;
      r  = model(av, bv, 1'b0);
      send(av, bv, 1'b0);
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("hold_reached_done", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_flags", {29'd0, lt, eq, gt}, {29'd0, r});
      end
      in_valid = 1'b0;
      or_mode = 2;
      drain();

      // Reset in the middle of BUSY abandons the operation
      send(32'h1234_5678, 32'h1234_5678, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q.delete();
      @(negedge clk);
      chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midreset_flags", {29'd0, lt, eq, gt}, 32'd0);
      send(32'h0000_0010, 32'h0000_0020, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
